// File: rtl/fp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_div_seq : sequential IEEE-754 divider, res = n / x, one bit per clock  |
// | Build option FPDIV_RNE_EN: round-to-nearest-even (default: truncate).     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   n,
  input  logic [EXP_W+MAN_W:0]   x,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [4:0]             flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EW    = EXP_W + 2;
  localparam int QW    = MAN_W + 3;
  localparam int CNT_W = $clog2(QW);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(QW - 1);
  localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    E_OVF    = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0]     INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FPDIV_RNE_EN
  localparam logic [W-2:0]     OVF_MAG  = INF_MAG;
`else
  localparam logic [W-2:0]     OVF_MAG  = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif

  typedef enum logic [1:0] {IDLE, DIV, NORM, PACK} state_t;
  state_t state;

  // operand unpacking and classification (subnormals flush to zero)
  logic             sn, sx;
  logic [EXP_W-1:0] en, ex;
  logic [MAN_W-1:0] mn, mx;
  assign {sn, en, mn} = n;
  assign {sx, ex, mx} = x;

  logic n_zero, x_zero, n_inf, x_inf, n_nan, x_nan;
  assign n_zero = (en == '0);
  assign x_zero = (ex == '0);
  assign n_inf  = (&en) & (mn == '0);
  assign x_inf  = (&ex) & (mx == '0);
  assign n_nan  = (&en) & (mn != '0);
  assign x_nan  = (&ex) & (mx != '0);

  logic          res_sign;
  logic          spec_hit;
  logic [W-1:0]  spec_val;
  logic [4:0]    spec_flg;

  always_comb begin
    res_sign = sn ^ sx;
    spec_hit = 1'b1;
    spec_val = '0;
    spec_flg = '0;
    if (n_nan | x_nan | (n_zero & x_zero) | (n_inf & x_inf)) begin
      spec_val = QNAN;
      spec_flg = 5'b10000;
    end else if (n_inf) begin
      spec_val = {res_sign, INF_MAG};
    end else if (x_zero) begin
      spec_val = {res_sign, INF_MAG};
      spec_flg = 5'b01000;
    end else if (x_inf | n_zero) begin
      spec_val = {res_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [EW-1:0] e_init;
  assign e_init = {2'b00, en} - {2'b00, ex} + BIAS;

  // datapath registers
  logic [MAN_W+1:0] rem;
  logic [MAN_W:0]   dvs;
  logic [QW-1:0]    quo;
  logic [EW-1:0]    e;
  logic [CNT_W-1:0] cnt;
  logic             sign;
  logic [MAN_W-1:0] man;
  logic             guard, sticky;
  logic             special;
  logic [W-1:0]     spec_res;
  logic [4:0]       spec_flags;

  // restoring step: borrow of the trial subtraction decides the quotient bit
  logic [MAN_W+2:0] diff;
  logic             ge;
  logic [MAN_W+1:0] kept;
  assign diff = {1'b0, rem} - {2'b00, dvs};
  assign ge   = ~diff[MAN_W+2];
  assign kept = ge ? diff[MAN_W+1:0] : rem;

  // rounding and range check
  logic             rnd_inc;
  logic [MAN_W:0]   sum;
  logic [EW-1:0]    e_rnd;
  logic             ovf, unf;
`ifdef FPDIV_RNE_EN
  assign rnd_inc = guard & (sticky | man[0]);
`else
  assign rnd_inc = 1'b0;
`endif
  assign sum   = {1'b0, man} + {{MAN_W{1'b0}}, rnd_inc};
  assign e_rnd = e + {{(EW-1){1'b0}}, sum[MAN_W]};
  assign ovf   = $signed(e_rnd) >= $signed(E_OVF);
  assign unf   = e_rnd[EW-1] | (e_rnd == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      res        <= '0;
      flags      <= '0;
      rem        <= '0;
      dvs        <= '0;
      quo        <= '0;
      e          <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
      man        <= '0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      special    <= 1'b0;
      spec_res   <= '0;
      spec_flags <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state == DIV) || (state == NORM);
      case (state)
        IDLE: begin
          if (start) begin
            sign       <= res_sign;
            special    <= spec_hit;
            spec_res   <= spec_val;
            spec_flags <= spec_flg;
            if (spec_hit) begin
              state <= PACK;
            end else begin
              rem   <= {2'b01, mn};
              dvs   <= {1'b1, mx};
              quo   <= '0;
              e     <= e_init;
              cnt   <= DIV_LAST;
              state <= DIV;
            end
          end
        end
        DIV: begin
          quo <= {quo[QW-2:0], ge};
          rem <= kept << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= NORM;
        end
        NORM: begin
          if (quo[QW-1]) begin
            man    <= quo[MAN_W+1:2];
            guard  <= quo[1];
            sticky <= quo[0] | (rem != '0);
          end else begin
            man    <= quo[MAN_W:1];
            guard  <= quo[0];
            sticky <= (rem != '0);
            e      <= e - 1'b1;
          end
          state <= PACK;
        end
        PACK: begin
          done  <= 1'b1;
          state <= IDLE;
          if (special) begin
            res   <= spec_res;
            flags <= spec_flags;
          end else if (ovf) begin
            res   <= {sign, OVF_MAG};
            flags <= 5'b00101;
          end else if (unf) begin
            res   <= {sign, {(W-1){1'b0}}};
            flags <= 5'b00011;
          end else begin
            res   <= {sign, e_rnd[EXP_W-1:0], sum[MAN_W-1:0]};
            flags <= {4'b0000, guard | sticky};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fp_div_seq.md
# fp_div_seq

Parametrised sequential IEEE-754 floating-point divider. It is the successor to the fixed single-precision divider and computes `res = n / x` one quotient bit per clock. It adds a start/done handshake, configurable exponent and mantissa widths, full special-case handling and exception flags. It sits in the arithmetic datapath next to the FP adder and is shared by the calculator top level.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored mantissa width, hidden bit excluded. Total width is `W = 1+EXP_W+MAN_W`.
- `clk`, input, 1: rising-edge clock; all state is in this domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request strobe; sampled only while `busy`=0.
- `n`, input, W: dividend; sampled on the accepted `start` cycle.
- `x`, input, W: divisor; sampled on the accepted `start` cycle.
- `busy`, output, 1: high from the cycle after acceptance until `done`.
- `done`, output, 1: one-cycle pulse when `res` and `flags` become valid.
- `res`, output, W: quotient; held until the next accepted `start`.
- `flags`, output, 5: `{invalid, div_by_zero, overflow, underflow, inexact}`; held with `res`.

## Operation
- FSM states: IDLE, DIV, NORM, PACK.
- IDLE, `start`=1:
  - Unpack both operands.
  - Special operand: result is written directly and the FSM goes to PACK.
  - Otherwise: load dividend mantissa `1.ma`, divisor mantissa `1.mb` and `e = ea - eb + BIAS` (signed, EXP_W+2 bits, BIAS = 2^(EXP_W-1)-1), then go to DIV.
- Subnormal inputs (exp=0) are treated as zero; this is flush-to-zero.
- Special-case priority:
  1. Any NaN, 0/0 or inf/inf gives canonical qNaN (sign 0, exp all-ones, mantissa MSB=1, rest 0) and sets `invalid`.
  2. finite-nonzero/0 gives ±inf and sets `div_by_zero`.
  3. inf/finite gives ±inf.
  4. finite/inf and 0/nonzero give ±0.
  5. No flags for cases 3 and 4.
- Sign of every non-NaN result is `sn ^ sx`.
- DIV: restoring radix-2 division, one bit per cycle, MAN_W+3 cycles, producing quotient `q[MAN_W+2:0]` and remainder `r`.
- NORM:
  - `q[MAN_W+2]`=1: mantissa = `q[MAN_W+1:2]`, guard = `q[1]`, sticky = `q[0] | (r!=0)`.
  - `q[MAN_W+2]`=0: mantissa = `q[MAN_W:1]`, guard = `q[0]`, sticky = `r!=0`, and `e = e-1`.
- PACK:
  - Apply rounding (see Configuration). A carry out of the mantissa increments `e`.
  - `e >= 2^EXP_W-1`: overflow result, and sets `overflow` and `inexact`.
  - `e <= 0`: ±0 (no subnormal outputs), and sets `underflow` and `inexact`.
  - Otherwise pack normally; `inexact = guard | sticky`.
  - PACK asserts `done` and returns to IDLE.
- `start` while `busy`=1 is ignored; the operation in flight and its inputs are unaffected.
- `start` on the same cycle as `done` is ignored, because the FSM is not yet in IDLE; it is accepted on the following cycle.

## Timing
- Reset state:
  - Asynchronous `rst_n`=0 forces IDLE.
  - `busy`=0, `done`=0, `res`=0, `flags`=0, all internal registers 0.
  - Reset asserted mid-operation aborts the operation; no `done` is produced.
- Let acceptance be cycle 0 (the edge at which `start` is sampled).
- Special operands: `done`=1 in cycle 1; `busy` stays 0.
- Normal operands:
  - `busy`=1 during cycles 1..MAN_W+4.
  - `done`=1 in cycle MAN_W+5, which is 28 cycles for the default widths.
- `res` and `flags` update on the same edge that raises `done`, and are stable afterwards.
- Throughput: one operation per MAN_W+6 cycles for back-to-back requests.

## Configuration
- `FPDIV_RNE_EN` defined: round-to-nearest-even.
  - Increment the mantissa if `guard & (sticky | lsb)`.
  - Overflow result is ±inf.
- `FPDIV_RNE_EN` not defined: round toward zero (truncate).
  - Overflow result is ±max-finite (exp = 2^EXP_W-2, mantissa all-ones).
  - `inexact` is still reported.
- Latency is identical in both builds.

## Test plan
- Default widths, `n`=0x40E00000 (7.0), `x`=0x40A00000 (5.0) → `res`=0x3FB33333 and `flags`=00001 in both builds; `done` exactly 28 cycles after `start`.
- `n`=0x3F800000, `x`=0x40400000 (1/3) → 0x3EAAAAAB with `FPDIV_RNE_EN`, 0x3EAAAAAA without; `inexact`=1. Then 0x40C00000 / 0x40000000 → 0x40400000 with `flags`=0.
- Specials, each with `done` in cycle 1:
  - 1.0/0.0 → 0x7F800000, flags 01000.
  - 0/0 → 0x7FC00000, flags 10000.
  - 0xFF800000/0x3F800000 → 0xFF800000, flags 00000.
- Overflow: 0x7F7FFFFF / 0x00800000 → 0x7F800000 (RNE) or 0x7F7FFFFF (truncate), flags 00101.
- Underflow: 0x00800000 / 0x40000000 → 0x00000000, flags 00011.
- `EXP_W`=5, `MAN_W`=10:
  - 0x4700/0x4500 → 0x3D9A (RNE) or 0x3D99 (truncate), `done` at cycle 15.
  - Pulse `start` with other operands mid-run: ignored.
  - Drop `rst_n` at cycle 5 of a second run: all outputs return to 0 and no `done` is produced.
